// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: forward-select and FSM state encodings shared by the hazard controller.
package hazard_ctrl_pkg;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;
    typedef enum logic [1:0] {HZ_RUN = 2'd0, HZ_MWAIT = 2'd1, HZ_ERR = 2'd2} hz_state_e;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: picks one operand source, with M-stage results beating W-stage results.
module fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int RFIDX_WIDTH = 5
) (
    input  logic [RFIDX_WIDTH-1:0] rs,
    input  logic [RFIDX_WIDTH-1:0] rdM,
    input  logic                   regwriteM,
    input  logic                   menM,
    input  logic [RFIDX_WIDTH-1:0] rdW,
    input  logic                   regwriteW,
    output logic [1:0]             sel
);
    logic hit_m, hit_w;
    assign hit_m = menM && regwriteM && (rdM != '0) && (rdM == rs);
    assign hit_w = regwriteW && (rdW != '0) && (rdW == rs);
    assign sel   = hit_m ? FWD_M : hit_w ? FWD_W : FWD_REG;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control, memory wait sequencing with watchdog trap,
// and stall/redirect event counters for the five-stage core.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RFIDX_WIDTH = 5,
    parameter int CNT_WIDTH   = 32,
    parameter int TIMEOUT     = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RFIDX_WIDTH-1:0] rs1D,
    input  logic [RFIDX_WIDTH-1:0] rs2D,
    input  logic [RFIDX_WIDTH-1:0] rs1E,
    input  logic [RFIDX_WIDTH-1:0] rs2E,
    input  logic [RFIDX_WIDTH-1:0] rdE,
    input  logic [RFIDX_WIDTH-1:0] rdM,
    input  logic [RFIDX_WIDTH-1:0] rdW,
    input  logic                   regwriteE,
    input  logic                   regwriteM,
    input  logic                   regwriteW,
    input  logic                   memtoregE,
    input  logic                   memtoregM,
    input  logic                   branchD,
    input  logic                   pcsrcD,
    input  logic                   memreqM,
    input  logic                   memreadyM,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   stallM,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   flushW,
    output logic [1:0]             forwardaE,
    output logic [1:0]             forwardbE,
    output logic [1:0]             forwardaD,
    output logic [1:0]             forwardbD,
    output logic                   memerr,
    output logic [CNT_WIDTH-1:0]   stallcnt,
    output logic [CNT_WIDTH-1:0]   redircnt
);
    localparam int WW = $clog2(TIMEOUT);

    hz_state_e            state_q, state_d;
    logic [WW-1:0]        waitcnt_q, waitcnt_d;
    logic [CNT_WIDTH-1:0] stallcnt_q, redircnt_q;
    logic [1:0]           fae, fbe, fad, fbd;
    logic                 mw, lu, bh, hz, err, e_hit, m_hit;

    fwd_sel #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_fae (.rs(rs1E), .rdM(rdM), .regwriteM(regwriteM), .menM(1'b1),
        .rdW(rdW), .regwriteW(regwriteW), .sel(fae));
    fwd_sel #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_fbe (.rs(rs2E), .rdM(rdM), .regwriteM(regwriteM), .menM(1'b1),
        .rdW(rdW), .regwriteW(regwriteW), .sel(fbe));
    fwd_sel #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_fad (.rs(rs1D), .rdM(rdM), .regwriteM(regwriteM), .menM(!memtoregM),
        .rdW(rdW), .regwriteW(regwriteW), .sel(fad));
    fwd_sel #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_fbd (.rs(rs2D), .rdM(rdM), .regwriteM(regwriteM), .menM(!memtoregM),
        .rdW(rdW), .regwriteW(regwriteW), .sel(fbd));

    assign e_hit = regwriteE && (rdE != '0) && (rdE == rs1D || rdE == rs2D);
    assign m_hit = regwriteM && (rdM != '0) && (rdM == rs1D || rdM == rs2D);
    assign mw    = memreqM && !memreadyM;
    assign lu    = memtoregE && e_hit;
    // A load still in M cannot be forwarded to the D comparator, so it also stalls a branch.
    assign bh    = branchD && (e_hit || (memtoregM && m_hit));
    assign hz    = lu || bh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HZ_RUN;
            waitcnt_q  <= '0;
            stallcnt_q <= '0;
            redircnt_q <= '0;
        end else begin
            state_q    <= state_d;
            waitcnt_q  <= waitcnt_d;
            stallcnt_q <= stallcnt_q + CNT_WIDTH'(stallF);
            redircnt_q <= redircnt_q + CNT_WIDTH'(flushD);
        end
    end

    always_comb begin
        state_d   = state_q;
        waitcnt_d = waitcnt_q;
        if (state_q == HZ_RUN && mw) begin
            state_d   = HZ_MWAIT;
            waitcnt_d = WW'(1);
        end else if (state_q == HZ_MWAIT) begin
            state_d   = !mw ? HZ_RUN : (waitcnt_q == WW'(TIMEOUT - 1)) ? HZ_ERR : HZ_MWAIT;
            waitcnt_d = !mw ? '0 : waitcnt_q + WW'(1);
        end
    end

    always_comb begin
        err       = state_q == HZ_ERR;
        stallF    = reset && (err || mw || hz);
        stallD    = reset && (err || mw || hz);
        stallE    = reset && (err || mw);
        stallM    = reset && (err || mw);
        flushW    = reset && !err && mw;
        flushE    = reset && !err && !mw && hz;
        flushD    = reset && !err && !mw && !hz && pcsrcD;
        forwardaE = reset ? fae : FWD_REG;
        forwardbE = reset ? fbe : FWD_REG;
        forwardaD = reset ? fad : FWD_REG;
        forwardbD = reset ? fbd : FWD_REG;
        memerr    = err;
        stallcnt  = stallcnt_q;
        redircnt  = redircnt_q;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios then randomized traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int TO = 4;

    logic clk = 0;
    logic reset;
    logic [RW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, pcsrcD, memreqM, memreadyM;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, memerr;
    logic [1:0] forwardaE, forwardbE, forwardaD, forwardbD;
    logic [CW-1:0] stallcnt, redircnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_err;
    int m_consec, m_stall, m_redir;

    always #5 clk = ~clk;

    hazard_ctrl #(.RFIDX_WIDTH(RW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
        .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
        .pcsrcD(pcsrcD), .memreqM(memreqM), .memreadyM(memreadyM), .stallF(stallF), .stallD(stallD),
        .stallE(stallE), .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardaE(forwardaE), .forwardbE(forwardbE), .forwardaD(forwardaD), .forwardbD(forwardbD),
        .memerr(memerr), .stallcnt(stallcnt), .redircnt(redircnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hit(logic we, logic [RW-1:0] rd, logic [RW-1:0] rs);
        return we && rd != 0 && rd == rs;
    endfunction

    function automatic logic [1:0] fwd_ref(logic [RW-1:0] rs, bit m_ok);
        if (m_ok && hit(regwriteM, rdM, rs)) return 2'b10;
        if (hit(regwriteW, rdW, rs)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, pcsrcD, memreqM, memreadyM} = '0;
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic step();
        logic [6:0] e;
        logic [7:0] f;
        bit lu, bh, mw;
        #4;
        mw = memreqM && !memreadyM;
        lu = memtoregE && (hit(regwriteE, rdE, rs1D) || hit(regwriteE, rdE, rs2D));
        bh = branchD && (hit(regwriteE, rdE, rs1D) || hit(regwriteE, rdE, rs2D) ||
             (memtoregM && (hit(regwriteM, rdM, rs1D) || hit(regwriteM, rdM, rs2D))));
        if (!reset)        e = 7'b0000000;
        else if (m_err)    e = 7'b1111000;
        else if (mw)       e = 7'b1111001;
        else if (lu || bh) e = 7'b1100010;
        else if (pcsrcD)   e = 7'b0000100;
        else               e = 7'b0000000;
        f = reset ? {fwd_ref(rs1E, 1), fwd_ref(rs2E, 1), fwd_ref(rs1D, !memtoregM), fwd_ref(rs2D, !memtoregM)} : 8'h00;
        check("ctl", {stallF, stallD, stallE, stallM, flushD, flushE, flushW}, e);
        check("fwd", {forwardaE, forwardbE, forwardaD, forwardbD}, f);
        @(posedge clk);
        if (!reset) begin
            m_err = 0; m_consec = 0; m_stall = 0; m_redir = 0;
        end else begin
            if (e[6]) m_stall = (m_stall + 1) % 16;
            if (e[2]) m_redir = (m_redir + 1) % 16;
            if (!m_err) begin
                m_consec = mw ? m_consec + 1 : 0;
                if (m_consec == TO) m_err = 1;
            end
        end
        #1;
        check("memerr", memerr, m_err);
        check("stallcnt", stallcnt, m_stall);
        check("redircnt", redircnt, m_redir);
    endtask

    task automatic pulse_reset();
        idle();
        reset = 0;
        step();
        reset = 1;
    endtask

    initial begin
        logic [CW-1:0] c0;
        reset = 0;
        idle();
        m_err = 0; m_consec = 0; m_stall = 0; m_redir = 0;
        @(posedge clk);
        #1;
        step();
        check("rst_stallF", stallF, 0);
        check("rst_cnt", stallcnt, 0);
        reset = 1;

        rs1E = 5; rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1;
        step();
        check("fwd_m_over_w", forwardaE, 2'b10);
        rdM = 0;
        step();
        check("fwd_w", forwardaE, 2'b01);
        regwriteW = 0;
        step();
        check("fwd_reg", forwardaE, 2'b00);

        idle();
        memtoregE = 1; regwriteE = 1; rdE = 7; rs2D = 7;
        c0 = stallcnt;
        step();
        check("lu_stall", {stallF, stallD, flushE}, 3'b111);
        check("lu_cnt", stallcnt, CW'(c0 + 1));
        rdE = 0;
        step();
        check("lu_rd0", stallF, 0);

        idle();
        branchD = 1; regwriteE = 1; rdE = 3; rs1D = 3; pcsrcD = 1;
        c0 = redircnt;
        step();
        check("bh_stall", {stallF, flushD}, 2'b10);
        regwriteE = 0;
        step();
        check("redir_flush", flushD, 1);
        check("redir_cnt", redircnt, CW'(c0 + 1));

        idle();
        memreqM = 1; pcsrcD = 1;
        c0 = stallcnt;
        repeat (3) begin
            step();
            check("mw_ctl", {stallF, stallD, stallE, stallM, flushW, flushD}, 6'b111110);
        end
        memreadyM = 1;
        step();
        check("mw_cnt", stallcnt, CW'(c0 + 3));
        check("mw_done", stallM, 0);

        pulse_reset();
        memreqM = 1;
        repeat (4) step();
        check("wd_trap", memerr, 1);
        memreadyM = 1;
        step();
        check("wd_sticky", memerr, 1);
        reset = 0;
        step();
        check("wd_rst_err", memerr, 0);
        check("wd_rst_cnt", stallcnt, 0);
        reset = 1;
        step();
        check("wd_run", stallE, 0);

        idle();
        memtoregE = 1; regwriteE = 1; rdE = 9; rs1D = 9;
        repeat (17) step();
        check("wrap", stallcnt, 1);

        for (int i = 0; i < 1500; i++) begin
            reset = $urandom_range(0, 49) != 0;
            rs1D = RW'($urandom_range(0, 3)); rs2D = RW'($urandom_range(0, 3));
            rs1E = RW'($urandom_range(0, 3)); rs2E = RW'($urandom_range(0, 3));
            rdE = RW'($urandom_range(0, 3)); rdM = RW'($urandom_range(0, 3)); rdW = RW'($urandom_range(0, 3));
            regwriteE = $urandom_range(0, 3) != 0; regwriteM = $urandom_range(0, 3) != 0;
            regwriteW = $urandom_range(0, 3) != 0;
            memtoregE = $urandom_range(0, 1) == 1; memtoregM = $urandom_range(0, 1) == 1;
            branchD = $urandom_range(0, 1) == 1; pcsrcD = $urandom_range(0, 1) == 1;
            memreqM = $urandom_range(0, 2) == 0; memreadyM = $urandom_range(0, 1) == 1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
